// File: rtl/raytracing_nios2_cpu_ocimem_arbiter_pkg.sv
// Shared types and constants for the OCI debug-RAM arbiter.
package raytracing_nios2_cpu_ocimem_arbiter_pkg;

  // Default geometry of the OCI debug RAM.
  localparam int OCI_ADDR_W = 8;
  localparam int OCI_DATA_W = 32;

  // JTAG shift register layout: address in [33:26], write data in [34:3].
  // The two fields overlap; each op type only looks at the one it needs.
  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_LSB = 26;
  localparam int JDO_ADDR_MSB = 33;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;

  // Arbiter / RAM sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_JTAG_RD_ADDR = 3'd1,
    ST_JTAG_RD_DATA = 3'd2,
    ST_JTAG_WR      = 3'd3,
    ST_AVS_RD_ADDR  = 3'd4,
    ST_AVS_RD_DATA  = 3'd5,
    ST_AVS_WR       = 3'd6
  } ocimem_state_e;

  // Kind of JTAG op waiting in the one-deep pending slot.
  typedef enum logic [1:0] {
    JOP_NONE    = 2'd0,
    JOP_RD_LOAD = 2'd1,  // ocimem_a: load address from jdo, read, no increment
    JOP_RD_INC  = 2'd2,  // no_action_a: read at current address, then increment
    JOP_WR      = 2'd3   // ocimem_b: write jdo data, then increment
  } jtag_op_e;

  // Side that won the previous arbitration.
  typedef enum logic {
    GNT_JTAG = 1'b0,
    GNT_AVS  = 1'b1
  } grant_e;

  function automatic logic is_jtag_state(ocimem_state_e s);
    return (s == ST_JTAG_RD_ADDR) || (s == ST_JTAG_RD_DATA) || (s == ST_JTAG_WR);
  endfunction

  // States in which an Avalon transfer finishes (waitrequest released).
  function automatic logic is_avs_done(ocimem_state_e s);
    return (s == ST_AVS_WR) || (s == ST_AVS_RD_DATA);
  endfunction

endpackage

// File: rtl/raytracing_nios2_cpu_ocimem_jtag_cmd.sv
// JTAG command front end: one-deep pending op, sticky overrun flag and the
// auto-incrementing debug-RAM address.
module raytracing_nios2_cpu_ocimem_jtag_cmd
  import raytracing_nios2_cpu_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = OCI_ADDR_W,
  parameter int DATA_W = OCI_DATA_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [JDO_W-1:0]  jdo_i,
  input  logic              take_action_ocimem_a_i,
  input  logic              take_no_action_ocimem_a_i,
  input  logic              take_action_ocimem_b_i,
  input  logic              inflight_i,  // arbiter is executing a JTAG op
  input  logic              grant_i,     // arbiter consumes the pending op
  output jtag_op_e          pend_op_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wrdata_o,
  output logic              overrun_o
);

  jtag_op_e          pend_op_q, pend_op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic              overrun_q, overrun_d;
  logic              any_strobe;
  logic              busy;

  // Only some jdo bits carry fields; the rest are deliberately ignored.
  logic unused_jdo;
  assign unused_jdo = ^jdo_i;

  assign any_strobe = take_action_ocimem_a_i | take_no_action_ocimem_a_i |
                      take_action_ocimem_b_i;
  assign busy       = (pend_op_q != JOP_NONE) | inflight_i;

  // Next state: consume on grant, capture a new strobe only when fully idle.
  always_comb begin
    pend_op_d = pend_op_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    overrun_d = overrun_q;
    if (grant_i) begin
      pend_op_d = JOP_NONE;
      // ocimem_a re-reads the loaded address; the other ops step past it.
      if (pend_op_q != JOP_RD_LOAD) addr_d = addr_q + ADDR_W'(1);
    end
    if (any_strobe) begin
      if (busy) begin
        overrun_d = 1'b1;
      end else if (take_action_ocimem_b_i) begin
        pend_op_d = JOP_WR;
        wrdata_d  = jdo_i[JDO_DATA_LSB +: DATA_W];
      end else if (take_action_ocimem_a_i) begin
        pend_op_d = JOP_RD_LOAD;
        addr_d    = jdo_i[JDO_ADDR_LSB +: ADDR_W];
      end else begin
        pend_op_d = JOP_RD_INC;
      end
    end
  end

  // Command registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_op_q <= JOP_NONE;
      addr_q    <= '0;
      wrdata_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      pend_op_q <= pend_op_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      overrun_q <= overrun_d;
    end
  end

  assign pend_op_o = pend_op_q;
  assign addr_o    = addr_q;
  assign wrdata_o  = wrdata_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/raytracing_nios2_cpu_ocimem_arbiter.sv
// Arbitrates the OCI debug RAM between JTAG debug ops and the Avalon debug
// slave, round robin on contention, one op in flight at a time.
module raytracing_nios2_cpu_ocimem_arbiter
  import raytracing_nios2_cpu_ocimem_arbiter_pkg::*;
#(
  parameter int ADDR_W = OCI_ADDR_W,
  parameter int DATA_W = OCI_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_waitrequest,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_wren,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_wrdata,
  input  logic [DATA_W-1:0]   ram_rddata,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                jtag_busy,
  output logic                jtag_overrun
);

  ocimem_state_e       state_q;
  grant_e              last_grant_q;
  logic [ADDR_W-1:0]   ram_address_q;
  logic                ram_wren_q;
  logic [DATA_W/8-1:0] ram_be_q;
  logic [DATA_W-1:0]   ram_wrdata_q;
  logic [DATA_W-1:0]   mon_q;

  jtag_op_e            jtag_op;
  logic [ADDR_W-1:0]   jtag_addr;
  logic [DATA_W-1:0]   jtag_wrdata;
  logic                jtag_pend;
  logic                avs_req;
  logic                jtag_win;
  logic                avs_win;
  logic                jtag_grant;

  raytracing_nios2_cpu_ocimem_jtag_cmd #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_jtag_cmd (
    .clk_i                     (clk),
    .reset_i                   (reset),
    .jdo_i                     (jdo),
    .take_action_ocimem_a_i    (take_action_ocimem_a),
    .take_no_action_ocimem_a_i (take_no_action_ocimem_a),
    .take_action_ocimem_b_i    (take_action_ocimem_b),
    .inflight_i                (is_jtag_state(state_q)),
    .grant_i                   (jtag_grant),
    .pend_op_o                 (jtag_op),
    .addr_o                    (jtag_addr),
    .wrdata_o                  (jtag_wrdata),
    .overrun_o                 (jtag_overrun)
  );

  // Arbitration is only meaningful in IDLE; on a tie the side that did not
  // win last time gets the RAM.
  assign jtag_pend  = (jtag_op != JOP_NONE);
  assign avs_req    = avs_read | avs_write;
  assign jtag_win   = jtag_pend & (~avs_req | (last_grant_q == GNT_AVS));
  assign avs_win    = avs_req & ~jtag_win;
  assign jtag_grant = (state_q == ST_IDLE) & jtag_win;

  // Sequencer: grant in IDLE, then address/data phases or a single write cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GNT_JTAG;
      ram_address_q <= '0;
      ram_wren_q    <= 1'b0;
      ram_be_q      <= '0;
      ram_wrdata_q  <= '0;
      mon_q         <= '0;
    end else begin
      ram_wren_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (jtag_win) begin
            last_grant_q  <= GNT_JTAG;
            ram_address_q <= jtag_addr;
            if (jtag_op == JOP_WR) begin
              state_q      <= ST_JTAG_WR;
              ram_wren_q   <= 1'b1;
              ram_be_q     <= '1;
              ram_wrdata_q <= jtag_wrdata;
            end else begin
              state_q <= ST_JTAG_RD_ADDR;
            end
          end else if (avs_win) begin
            last_grant_q  <= GNT_AVS;
            ram_address_q <= avs_address;
            if (avs_write) begin
              state_q      <= ST_AVS_WR;
              ram_wren_q   <= 1'b1;
              ram_be_q     <= avs_byteenable;
              ram_wrdata_q <= avs_writedata;
            end else begin
              state_q <= ST_AVS_RD_ADDR;
            end
          end
        end
        ST_JTAG_RD_ADDR: state_q <= ST_JTAG_RD_DATA;
        ST_JTAG_RD_DATA: begin
          mon_q   <= ram_rddata;
          state_q <= ST_IDLE;
        end
        ST_AVS_RD_ADDR:  state_q <= ST_AVS_RD_DATA;
        default:         state_q <= ST_IDLE;
      endcase
    end
  end

  // Avalon stalls until its op reaches its final cycle; the RAM output is
  // presented directly as read data in that cycle.
  assign avs_waitrequest = avs_req & ~is_avs_done(state_q);
  assign avs_readdata    = ram_rddata;

  assign ram_address     = ram_address_q;
  assign ram_wren        = ram_wren_q;
  assign ram_byteenable  = ram_be_q;
  assign ram_wrdata      = ram_wrdata_q;
  assign MonDReg         = mon_q;
  assign jtag_busy       = jtag_pend | is_jtag_state(state_q);

endmodule

// File: doc/raytracing_nios2_cpu_ocimem_arbiter.md
RAYTRACING_NIOS2_CPU_OCIMEM_ARBITER -- requirements
Module: raytracing_nios2_cpu_ocimem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the OCI debug RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the RAM word width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; ports clk and reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 jdo  in  38  JTAG shift data: address in jdo[33:26], write data in jdo[34:3].
REQ-007 take_action_ocimem_a  in  1  one-cycle strobe: load JTAG address and read it.
REQ-008 take_no_action_ocimem_a  in  1  one-cycle strobe: read at JTAG address, then increment it.
REQ-009 take_action_ocimem_b  in  1  one-cycle strobe: write jdo data at JTAG address, then increment it.
REQ-010 avs_address / avs_read / avs_write  in  ADDR_W/1/1  Avalon debug-slave request.
REQ-011 avs_writedata / avs_byteenable  in  DATA_W/4  Avalon write data and byte lanes.
REQ-012 avs_readdata / avs_waitrequest  out  DATA_W/1  Avalon read data and stall.
REQ-013 ram_address / ram_wren / ram_byteenable / ram_wrdata  out  ADDR_W/1/4/DATA_W  RAM port.
REQ-014 ram_rddata  in  DATA_W  RAM read data, valid one cycle after ram_address.
REQ-015 MonDReg  out  DATA_W  last JTAG read result, held until the next JTAG read.
REQ-016 jtag_busy / jtag_overrun  out  1/1  JTAG op pending or in flight / sticky dropped-strobe flag.

Function
REQ-017 SHALL capture each JTAG strobe into a one-deep pending register; priority when strobes coincide: ocimem_b > ocimem_a > no_action_a.
REQ-018 A strobe arriving while a JTAG op is pending or in flight SHALL be dropped and SHALL set jtag_overrun.
REQ-019 FSM states: IDLE, JTAG_RD_ADDR, JTAG_RD_DATA, JTAG_WR, AVS_RD_ADDR, AVS_RD_DATA, AVS_WR.
REQ-020 IDLE: if only one side requests, grant it; if both, grant the side not granted last (round robin, last_grant resets to JTAG, so Avalon wins the first tie).
REQ-021 Reads SHALL go *_RD_ADDR (ram_address driven) -> *_RD_DATA (ram_rddata captured) -> IDLE; writes SHALL go *_WR (ram_wren=1 for exactly one cycle) -> IDLE.
REQ-022 Avalon address, writedata and byteenable SHALL be sampled at grant; avs_waitrequest SHALL be high whenever avs_read|avs_write and the op is not completing this cycle.
REQ-023 Avalon op completes with avs_waitrequest low in AVS_WR or AVS_RD_DATA; there avs_readdata = ram_rddata.
REQ-024 Uncontended Avalon write latency SHALL be 2 cycles; uncontended Avalon read latency SHALL be 3 cycles, counted from request to the waitrequest-low cycle.
REQ-025 JTAG writes SHALL drive ram_byteenable=4'hF; JTAG reads SHALL load MonDReg in JTAG_RD_DATA.
REQ-026 jtag_addr SHALL increment modulo 2^ADDR_W after ocimem_b and no_action_a ops: 8'hFF wraps to 8'h00.
REQ-027 ram_wren SHALL be 0 in every state other than the *_WR states; ram_address SHALL hold its last value in IDLE.
REQ-028 jtag_busy = pending | FSM in any JTAG_* state.

Reset
REQ-029 reset SHALL force, without waiting for clk: FSM=IDLE, pending cleared, jtag_addr=0, MonDReg=0, ram_wren=0, avs_waitrequest follows REQ-022 from IDLE, jtag_overrun=0, last_grant=JTAG.
REQ-030 Reset mid-operation SHALL abort the op with no RAM write issued after reset assertion; an aborted Avalon master sees waitrequest held high and re-arbitrates.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, the ADDR_W/DATA_W defaults and the jdo field position constants.
REQ-032 JTAG strobe capture, overrun and address counter SHALL be one sub-module, raytracing_nios2_cpu_ocimem_jtag_cmd.

Verification
REQ-033 take_action_ocimem_a with jdo[33:26]=8'h10, RAM[0x10]=0xDEADBEEF -> MonDReg=0xDEADBEEF 3 cycles later; jtag_addr stays 0x10.
REQ-034 take_action_ocimem_b with jtag_addr=0xFF, data 0x12345678 -> one ram_wren pulse at 0xFF with byteenable 4'hF; jtag_addr becomes 0x00.
REQ-035 Avalon read and JTAG no_action_a asserted in the same cycle from reset -> Avalon served first (waitrequest low on cycle 3), JTAG read follows; the next tie goes to JTAG.
REQ-036 Second ocimem_b strobe one cycle after the first -> only one RAM write, jtag_overrun=1 until reset.
REQ-037 Reset asserted during AVS_RD_ADDR -> FSM=IDLE and ram_wren=0 immediately, MonDReg=0; the held Avalon read then completes with correct data.
REQ-038 Avalon write with byteenable 4'b0011 at 0x05 -> ram_wren for one cycle with byteenable 4'b0011, waitrequest low 2 cycles after the request.
